// File: rtl/loader_pkg.sv
// Shared definitions for the instruction-memory stream loader.
package loader_pkg;

   // Bytes that make up one instruction word on the stream.
   localparam int BYTES_PER_WORD = 4;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LEN   = 3'd1,
      ST_LOAD  = 3'd2,
      ST_CSUM  = 3'd3,
      ST_DONE  = 3'd4,
      ST_ERROR = 3'd5
   } state_e;

   // States in which the loader consumes stream bytes.
   function automatic logic rx_open(state_e s);
      return (s == ST_LEN) || (s == ST_LOAD) || (s == ST_CSUM);
   endfunction

   // States in which a Start pulse begins a new load.
   function automatic logic start_ok(state_e s);
      return (s == ST_IDLE) || (s == ST_DONE) || (s == ST_ERROR);
   endfunction

endpackage

// File: rtl/byte_word_assembler.sv
// Packs accepted stream bytes into 32-bit little-endian words.
// word_o is the word that the current byte completes, so it is only
// meaningful while word_valid_o is high.
module byte_word_assembler
   import loader_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic [7:0]  byte_i,
   input  logic        accept_i,
   input  logic        clear_i,
   output logic [31:0] word_o,
   output logic        word_valid_o
);

   logic [1:0]  cnt_q, cnt_d;
   logic [31:0] shreg_q, shreg_d;

   // Newest byte enters at the top, so after four bytes the first one sits in [7:0].
   always_comb begin
      cnt_d   = cnt_q;
      shreg_d = shreg_q;
      if (clear_i) begin
         cnt_d   = '0;
         shreg_d = '0;
      end else if (accept_i) begin
         cnt_d   = cnt_q + 2'd1;
         shreg_d = {byte_i, shreg_q[31:8]};
      end
   end

   // Byte counter and shift register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q   <= '0;
         shreg_q <= '0;
      end else begin
         cnt_q   <= cnt_d;
         shreg_q <= shreg_d;
      end
   end

   assign word_o       = {byte_i, shreg_q[31:8]};
   assign word_valid_o = accept_i && !clear_i && (cnt_q == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_stream_loader.sv
// Streams a length-prefixed, checksummed program image into instruction
// memory and holds the core in reset until the image is complete and valid.
module imem_stream_loader
   import loader_pkg::*;
#(
   parameter int MEM_WORDS = 64,
   parameter int AW        = 32
) (
   input  logic          CLK,
   input  logic          RESETn,
   input  logic          Start,
   input  logic [7:0]    RxData,
   input  logic          RxValid,
   output logic          RxReady,
   output logic          IMemWE,
   output logic [AW-1:0] IMemAddr,
   output logic [31:0]   IMemWData,
   output logic          CpuResetn,
   output logic          Busy,
   output logic          Done,
   output logic          Error
);

   localparam int WCW = $clog2(MEM_WORDS + 1);

   state_e          state_q, state_d;
   logic [31:0]     len_q, len_d;
   logic [WCW-1:0]  wcnt_q, wcnt_d;
   logic [7:0]      csum_q, csum_d;
   logic            we_q, we_d;
   logic [AW-1:0]   addr_q, addr_d;
   logic [31:0]     wdata_q, wdata_d;

   logic            rx_rdy;
   logic            rx_acc;
   logic            start_go;
   logic            asm_accept;
   logic [31:0]     asm_word;
   logic            asm_valid;

   assign rx_rdy     = rx_open(state_q);
   assign rx_acc     = RxValid && rx_rdy;
   assign start_go   = Start && start_ok(state_q);
   // Length bytes and payload bytes share the same little-endian packing.
   assign asm_accept = rx_acc && ((state_q == ST_LEN) || (state_q == ST_LOAD));

   byte_word_assembler u_asm (
      .clk_i        (CLK),
      .rst_ni       (RESETn),
      .byte_i       (RxData),
      .accept_i     (asm_accept),
      .clear_i      (start_go),
      .word_o       (asm_word),
      .word_valid_o (asm_valid)
   );

   // Next-state, counters, checksum and the registered memory write port.
   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      wcnt_d  = wcnt_q;
      csum_d  = csum_q;
      we_d    = 1'b0;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      unique case (state_q)
         ST_IDLE, ST_DONE, ST_ERROR: begin
            if (start_go) begin
               state_d = ST_LEN;
               len_d   = '0;
               wcnt_d  = '0;
               csum_d  = '0;
            end
         end
         ST_LEN: begin
            if (asm_valid) begin
               len_d = asm_word;
               // Full 32-bit compare: high length bits must not alias into range.
               if (asm_word > 32'(MEM_WORDS)) begin
                  state_d = ST_ERROR;
               end else if (asm_word == 32'd0) begin
                  state_d = ST_CSUM;
               end else begin
                  state_d = ST_LOAD;
               end
            end
         end
         ST_LOAD: begin
            if (rx_acc) begin
               csum_d = csum_q ^ RxData;
            end
            if (asm_valid) begin
               we_d    = 1'b1;
               addr_d  = AW'(wcnt_q) << 2;
               wdata_d = asm_word;
               wcnt_d  = wcnt_q + WCW'(1);
               if ((32'(wcnt_q) + 32'd1) == len_q) begin
                  state_d = ST_CSUM;
               end
            end
         end
         ST_CSUM: begin
            if (rx_acc) begin
               state_d = (RxData == csum_q) ? ST_DONE : ST_ERROR;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and datapath registers; reset aborts any load in progress.
   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         state_q <= ST_IDLE;
         len_q   <= '0;
         wcnt_q  <= '0;
         csum_q  <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         wcnt_q  <= wcnt_d;
         csum_q  <= csum_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
      end
   end

   assign RxReady   = rx_rdy;
   assign Busy      = rx_rdy;
   assign IMemWE    = we_q;
   assign IMemAddr  = addr_q;
   assign IMemWData = wdata_q;
   assign Done      = (state_q == ST_DONE);
   assign CpuResetn = (state_q == ST_DONE);
   assign Error     = (state_q == ST_ERROR);

endmodule

// File: tb/tb_imem_stream_loader.sv
// Self-checking bench for imem_stream_loader: directed images from the
// test plan plus randomized images checked against a queue-based model.
module tb_imem_stream_loader;

   localparam int MEM_WORDS = 64;
   localparam int AW        = 32;

   logic          CLK = 1'b0;
   logic          RESETn = 1'b0;
   logic          Start = 1'b0;
   logic [7:0]    RxData = 8'h00;
   logic          RxValid = 1'b0;
   logic          RxReady;
   logic          IMemWE;
   logic [AW-1:0] IMemAddr;
   logic [31:0]   IMemWData;
   logic          CpuResetn;
   logic          Busy;
   logic          Done;
   logic          Error;

   imem_stream_loader #(.MEM_WORDS(MEM_WORDS), .AW(AW)) dut (
      .CLK       (CLK),
      .RESETn    (RESETn),
      .Start     (Start),
      .RxData    (RxData),
      .RxValid   (RxValid),
      .RxReady   (RxReady),
      .IMemWE    (IMemWE),
      .IMemAddr  (IMemAddr),
      .IMemWData (IMemWData),
      .CpuResetn (CpuResetn),
      .Busy      (Busy),
      .Done      (Done),
      .Error     (Error)
   );

   always #5 CLK = ~CLK;

   int vectors = 0;
   int miscompares = 0;

   // Captured memory writes, one entry per IMemWE cycle.
   logic [AW-1:0] wr_addr[$];
   logic [31:0]   wr_data[$];
   // Bytes to stream and the words the model expects to see written.
   logic [7:0]    img_q[$];
   logic [31:0]   exp_words[$];

   always @(negedge CLK) begin
      if (IMemWE) begin
         wr_addr.push_back(IMemAddr);
         wr_data.push_back(IMemWData);
      end
   end

   task automatic apply_reset();
      RESETn  = 1'b0;
      RxValid = 1'b0;
      Start   = 1'b0;
      repeat (2) @(negedge CLK);
      RESETn = 1'b1;
      @(negedge CLK);
      wr_addr.delete();
      wr_data.delete();
   endtask

   task automatic pulse_start();
      @(negedge CLK);
      Start = 1'b1;
      @(negedge CLK);
      Start = 1'b0;
   endtask

   // Streams img_q; gap idle cycles precede each byte (random 0..gap if rnd).
   // With noise set, Start is held high during the idle cycles.
   task automatic send_image(input int gap, input bit rnd, input bit noise);
      foreach (img_q[i]) begin
         int g;
         int t;
         g = rnd ? int'($urandom_range(gap, 0)) : gap;
         for (int k = 0; k < g; k++) begin
            @(negedge CLK);
            RxValid = 1'b0;
            RxData  = 8'($urandom);
            Start   = noise;
         end
         @(negedge CLK);
         Start   = 1'b0;
         RxData  = img_q[i];
         RxValid = 1'b1;
         t = 0;
         while (!RxReady) begin
            @(negedge CLK);
            t++;
            if (t > 20) begin
               vectors++;
               miscompares++;
               $display("FAIL send_byte_timeout: byte %0d RxReady=%b required 1", i, RxReady);
               RxValid = 1'b0;
               return;
            end
         end
      end
      @(negedge CLK);
      RxValid = 1'b0;
      Start   = 1'b0;
   endtask

   // Model: length prefix, little-endian payload, XOR checksum over payload.
   task automatic make_image(input bit bad);
      logic [31:0] n;
      logic [7:0]  cs;
      n  = 32'(exp_words.size());
      cs = 8'h00;
      img_q.delete();
      for (int k = 0; k < 4; k++) img_q.push_back(n[8*k +: 8]);
      foreach (exp_words[w]) begin
         for (int k = 0; k < 4; k++) begin
            img_q.push_back(exp_words[w][8*k +: 8]);
            cs = cs ^ exp_words[w][8*k +: 8];
         end
      end
      img_q.push_back(bad ? (cs ^ 8'(1 + $urandom_range(254, 0))) : cs);
   endtask

   task automatic test_reset();
      @(negedge CLK);
      vectors++;
      if ({RxReady, IMemWE, IMemAddr, IMemWData, CpuResetn, Busy, Done, Error} !== '0) begin
         miscompares++;
         $display("FAIL reset_outputs: rdy=%b we=%b addr=%h wd=%h cpurst=%b busy=%b done=%b err=%b required all 0",
                  RxReady, IMemWE, IMemAddr, IMemWData, CpuResetn, Busy, Done, Error);
      end
      RESETn = 1'b1;
      @(negedge CLK);
      vectors++;
      if (RxReady !== 1'b0 || Busy !== 1'b0) begin
         miscompares++;
         $display("FAIL idle_after_reset: rdy=%b busy=%b required 0 0", RxReady, Busy);
      end
      pulse_start();
      vectors++;
      if (RxReady !== 1'b1 || Busy !== 1'b1) begin
         miscompares++;
         $display("FAIL start_to_len: rdy=%b busy=%b required 1 1", RxReady, Busy);
      end
   endtask

   task automatic test_normal(input int gap, input bit noise, input string tag);
      apply_reset();
      pulse_start();
      img_q = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44,
                8'h55, 8'h66, 8'h77, 8'h88, 8'h88};
      send_image(gap, 1'b0, noise);
      vectors++;
      if (wr_addr.size() !== 2) begin
         miscompares++;
         $display("FAIL %s_write_count: got %0d required 2", tag, wr_addr.size());
      end else begin
         vectors++;
         if (wr_addr[0] !== 32'h0 || wr_data[0] !== 32'h44332211) begin
            miscompares++;
            $display("FAIL %s_word0: addr=%h data=%h required 0 44332211", tag, wr_addr[0], wr_data[0]);
         end
         vectors++;
         if (wr_addr[1] !== 32'h4 || wr_data[1] !== 32'h88776655) begin
            miscompares++;
            $display("FAIL %s_word1: addr=%h data=%h required 4 88776655", tag, wr_addr[1], wr_data[1]);
         end
      end
      vectors++;
      if ({Done, CpuResetn, Error, Busy, RxReady} !== 5'b11000) begin
         miscompares++;
         $display("FAIL %s_done_flags: done=%b cpurst=%b err=%b busy=%b rdy=%b required 1 1 0 0 0",
                  tag, Done, CpuResetn, Error, Busy, RxReady);
      end
   endtask

   task automatic test_start_in_done();
      @(negedge CLK);
      Start = 1'b1;
      @(negedge CLK);
      Start = 1'b0;
      vectors++;
      if ({CpuResetn, Done, Busy} !== 3'b001) begin
         miscompares++;
         $display("FAIL start_in_done: cpurst=%b done=%b busy=%b required 0 0 1", CpuResetn, Done, Busy);
      end
   endtask

   task automatic test_bad_csum();
      apply_reset();
      pulse_start();
      img_q = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44,
                8'h55, 8'h66, 8'h77, 8'h88, 8'h00};
      send_image(0, 1'b0, 1'b0);
      vectors++;
      if (wr_addr.size() !== 2) begin
         miscompares++;
         $display("FAIL bad_csum_writes: got %0d required 2", wr_addr.size());
      end
      vectors++;
      if ({Error, CpuResetn, Done} !== 3'b100) begin
         miscompares++;
         $display("FAIL bad_csum_flags: err=%b cpurst=%b done=%b required 1 0 0", Error, CpuResetn, Done);
      end
      // Reload a good image straight out of ERROR.
      pulse_start();
      vectors++;
      if (Error !== 1'b0 || Busy !== 1'b1) begin
         miscompares++;
         $display("FAIL error_restart: err=%b busy=%b required 0 1", Error, Busy);
      end
      wr_addr.delete();
      wr_data.delete();
      img_q[12] = 8'h88;
      send_image(1, 1'b0, 1'b0);
      vectors++;
      if (wr_addr.size() !== 2 || Done !== 1'b1 || CpuResetn !== 1'b1) begin
         miscompares++;
         $display("FAIL reload_after_error: writes=%0d done=%b cpurst=%b required 2 1 1",
                  wr_addr.size(), Done, CpuResetn);
      end
   endtask

   task automatic test_oversize();
      apply_reset();
      pulse_start();
      img_q = '{8'h41, 8'h00, 8'h00, 8'h00};
      send_image(0, 1'b0, 1'b0);
      vectors++;
      if ({Error, Busy, RxReady, CpuResetn} !== 4'b1000 || wr_addr.size() !== 0) begin
         miscompares++;
         $display("FAIL oversize_0x41: err=%b busy=%b rdy=%b cpurst=%b writes=%0d required 1 0 0 0 0",
                  Error, Busy, RxReady, CpuResetn, wr_addr.size());
      end
      pulse_start();
      img_q = '{8'h00, 8'h00, 8'h01, 8'h00};
      send_image(0, 1'b0, 1'b0);
      vectors++;
      if (Error !== 1'b1 || Busy !== 1'b0 || wr_addr.size() !== 0) begin
         miscompares++;
         $display("FAIL oversize_high_bits: err=%b busy=%b writes=%0d required 1 0 0",
                  Error, Busy, wr_addr.size());
      end
   endtask

   task automatic test_zero_len();
      apply_reset();
      pulse_start();
      img_q = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      send_image(0, 1'b0, 1'b0);
      vectors++;
      if (Done !== 1'b1 || CpuResetn !== 1'b1 || wr_addr.size() !== 0) begin
         miscompares++;
         $display("FAIL zero_len: done=%b cpurst=%b writes=%0d required 1 1 0", Done, CpuResetn, wr_addr.size());
      end
   endtask

   task automatic test_reset_mid_load();
      apply_reset();
      pulse_start();
      img_q = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
      send_image(0, 1'b0, 1'b0);
      RESETn = 1'b0;
      @(negedge CLK);
      vectors++;
      if ({RxReady, Busy, IMemWE, CpuResetn} !== 4'b0000) begin
         miscompares++;
         $display("FAIL mid_reset_outputs: rdy=%b busy=%b we=%b cpurst=%b required 0 0 0 0",
                  RxReady, Busy, IMemWE, CpuResetn);
      end
      RESETn = 1'b1;
      // Bytes offered while idle must be ignored.
      for (int k = 0; k < 8; k++) begin
         @(negedge CLK);
         RxValid = 1'b1;
         RxData  = 8'($urandom);
      end
      @(negedge CLK);
      RxValid = 1'b0;
      vectors++;
      if (wr_addr.size() !== 1 || Busy !== 1'b0) begin
         miscompares++;
         $display("FAIL mid_reset_writes: writes=%0d busy=%b required 1 0", wr_addr.size(), Busy);
      end else begin
         vectors++;
         if (wr_addr[0] !== 32'h0 || wr_data[0] !== 32'h44332211) begin
            miscompares++;
            $display("FAIL mid_reset_word0: addr=%h data=%h required 0 44332211", wr_addr[0], wr_data[0]);
         end
      end
   endtask

   task automatic test_random();
      apply_reset();
      for (int it = 0; it < 8; it++) begin
         int  n;
         bit  bad;
         n   = (it == 7) ? MEM_WORDS : int'($urandom_range(8, 1));
         bad = ($urandom_range(2, 0) == 0);
         exp_words.delete();
         for (int w = 0; w < n; w++) exp_words.push_back($urandom);
         make_image(bad);
         pulse_start();
         wr_addr.delete();
         wr_data.delete();
         send_image(2, 1'b1, 1'b0);
         vectors++;
         if (wr_addr.size() !== n) begin
            miscompares++;
            $display("FAIL rand%0d_write_count: got %0d required %0d", it, wr_addr.size(), n);
         end else begin
            foreach (exp_words[w]) begin
               vectors++;
               if (wr_addr[w] !== AW'(4 * w) || wr_data[w] !== exp_words[w]) begin
                  miscompares++;
                  $display("FAIL rand%0d_word%0d: addr=%h data=%h required %h %h",
                           it, w, wr_addr[w], wr_data[w], AW'(4 * w), exp_words[w]);
               end
            end
         end
         vectors++;
         if (Done !== !bad || Error !== bad || CpuResetn !== !bad) begin
            miscompares++;
            $display("FAIL rand%0d_end_flags: done=%b err=%b cpurst=%b required %b %b %b",
                     it, Done, Error, CpuResetn, !bad, bad, !bad);
         end
      end
   endtask

   initial begin
      test_reset();
      test_normal(0, 1'b0, "normal");
      test_start_in_done();
      test_normal(3, 1'b1, "gapped");
      test_bad_csum();
      test_oversize();
      test_zero_len();
      test_reset_mid_load();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/imem_stream_loader.md
Name: imem_stream_loader

Overview:
- Writer side of the instruction-memory interface. The `arm` core only fetches from this memory.
- Accepts a byte stream from the bench or a host link, assembles 32-bit little-endian words and writes them into instruction memory from byte address 0.
- Holds the core in reset until a complete, checksum-valid program image is loaded, then releases it.
- Lets `tb_arm`-style benches load arbitrary programs instead of relying on a hard-coded memory init file.

Parameters:
- MEM_WORDS, 64, instruction memory depth in 32-bit words; maximum accepted program length.
- AW, 32, width of the byte address driven to instruction memory.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- RESETn  input  1  asynchronous, active-low reset.
- Start  input  1  single-cycle pulse that begins a load; honoured in IDLE, DONE and ERROR.
- RxData  input  8  stream byte.
- RxValid  input  1  RxData is valid this cycle.
- RxReady  output  1  loader accepts a byte this cycle; a byte transfers when RxValid&RxReady.
- IMemWE  output  1  one-cycle write strobe to instruction memory.
- IMemAddr  output  AW  byte address of the write; always word-aligned (word_index*4).
- IMemWData  output  32  word being written.
- CpuResetn  output  1  active-low reset to the `arm` core; low except in DONE.
- Busy  output  1  high in LEN, LOAD and CSUM.
- Done  output  1  high in DONE.
- Error  output  1  high in ERROR.

Behaviour:
- Reset (RESETn low, asynchronous):
  - State=IDLE.
  - RxReady=0, IMemWE=0, IMemAddr=0, IMemWData=0.
  - CpuResetn=0, Busy=0, Done=0, Error=0.
  - Byte counter, word counter, length and checksum registers all cleared.
  - Reset asserted mid-load aborts immediately. Words already written stay in memory; no further writes occur.
- Stream format:
  - 4-byte length N, little-endian.
  - N words, each 4 bytes, little-endian: the first byte received lands in bits [7:0].
  - 1 checksum byte: the XOR of all 4N payload bytes. Length bytes are excluded.
- State IDLE: RxReady=0. Start -> LEN; clear the byte counter and set checksum=0.
- State LEN:
  - RxReady=1; accept 4 bytes into the N register.
  - After the 4th byte: N>MEM_WORDS -> ERROR; N==0 -> CSUM; otherwise -> LOAD.
- State LOAD:
  - RxReady=1. Each accepted byte shifts into the word register and XORs into the checksum.
  - On the 4th byte of a word, the next cycle drives IMemWE=1, IMemAddr=word_index*4 and IMemWData=assembled word; word_index then increments.
  - The write never stalls the stream: RxReady stays 1 during the write cycle, so back-to-back bytes are legal every cycle.
  - After word N-1 is assembled -> CSUM.
- State CSUM:
  - RxReady=1; accept 1 byte.
  - Byte equals checksum -> DONE; otherwise -> ERROR.
  - The final word's IMemWE may coincide with the first CSUM cycle.
- State DONE:
  - RxReady=0, CpuResetn=1, Done=1.
  - Start -> LEN; CpuResetn drops to 0 in the same edge as the transition.
- State ERROR:
  - RxReady=0, CpuResetn=0, Error=1.
  - Start -> LEN, which clears Error.
- Start while Busy is ignored.
- RxValid while RxReady=0 is ignored; the byte is neither consumed nor counted.
- Idle gaps (RxValid=0) of any length are allowed inside every state; counters hold.
- IMemWE is at most one cycle per word; IMemAddr and IMemWData hold their last values when IMemWE=0.
- Length bits above the log2(MEM_WORDS+1) needed bits are still compared, so N=0x0001_0000 triggers ERROR.

Decomposition:
- Shared package `loader_pkg`: state encoding (IDLE, LEN, LOAD, CSUM, DONE, ERROR) and the byte-per-word constant 4.
- One natural sub-module `byte_word_assembler`:
  - Inputs: byte, accept, clear.
  - Outputs: 32-bit word and word_valid pulse.
  - Owns the 2-bit byte counter and the little-endian shift register.
- The top level holds the FSM, word counter, length register and checksum.

Test Plan:
- Reset values: hold RESETn=0 -> all outputs 0 and CpuResetn=0. Release, then pulse Start -> next cycle RxReady=1 and Busy=1.
- Normal load, no gaps: bytes 02 00 00 00 | 11 22 33 44 | 55 66 77 88 | checksum CC, where CC = 0x11^0x22^0x33^0x44^0x55^0x66^0x77^0x88 -> writes addr 0x0=0x44332211 and addr 0x4=0x88776655. Then Done=1, CpuResetn=1, and the `arm` core starts fetching.
- Gapped stream: same image with RxValid low for 3 cycles between every byte -> identical writes, exactly 2 IMemWE pulses.
- Bad checksum: same image with checksum byte 0x00 -> both words written, then Error=1 and CpuResetn stays 0. Start reloads successfully.
- Oversize: length 0x41 with MEM_WORDS=64 -> ERROR right after the 4th length byte; no IMemWE.
- Edge cases:
  - Length 0 with checksum 0x00 -> DONE and no writes.
  - RESETn pulsed low after the 6th payload byte -> IDLE, no further writes.
  - Start issued in DONE -> CpuResetn falls next edge.
